shared_counter_ctrl: RTL and testbench
======================================

// Module: shared_counter_ctrl
// PURPOSE
//  Command front-end for a bank of NUM_SLICES subcounter slices (GRAN bits each). Slices are partitioned into
//  independent counters by a split mask; the block accepts per-counter commands (reset/increment/nop/load) over
//  a valid/ready handshake and drives each slice's 2-bit command, load enable and load data. Computes the
//  inter-slice carry chain from slice outputs and streams wide loads one slice (GRAN bits) per beat, LSB first.
// PARAMETERS
//  GRAN        4   bits per slice; must match the slice granularity
//  NUM_SLICES  8   slices in the bank
//  IDX_W       $clog2(NUM_SLICES)  slice index width (derived, do not override)
// PORTS
//  clk          in   1                 clock, all state on rising edge
//  rst          in   1                 asynchronous, active-high reset
//  cfg_we       in   1                 write split_mask into config register
//  cfg_mask     in   NUM_SLICES        bit i=1: slice i is LSB slice (base) of a counter
//  cmd_valid    in   1                 command request
//  cmd_ready    out  1                 command accepted when cmd_valid&&cmd_ready
//  cmd_op       in   2                 00 reset, 01 increment, 10 nop, 11 load
//  cmd_base     in   IDX_W             base slice index of target counter
//  ld_valid     in   1                 load beat valid (LOAD state only)
//  ld_ready     out  1                 load beat accepted when ld_valid&&ld_ready
//  ld_data      in   GRAN              load beat, LSB slice first
//  slice_data   in   GRAN*NUM_SLICES   current slice values; slice i at [i*GRAN +: GRAN]
//  sub_cmd      out  2*NUM_SLICES      slice i command at [2i+:2]: 00 reset,01 inc,10 idle,11 load
//  load_en      out  NUM_SLICES        per-slice load enable
//  load_data    out  GRAN*NUM_SLICES   ld_data replicated to every slice field
//  done         out  1                 1-cycle pulse: load completed
//  err          out  1                 1-cycle pulse: bad cmd_base, or cfg_we ignored
// BEHAVIOUR
//  - Config reg cfg: reset value all ones; bit 0 always reads 1 regardless of write. Counter at base b spans
//    slices b..e, e = (next set cfg bit above b)-1, else NUM_SLICES-1.
//  - FSM states INIT, IDLE, LOAD. rst -> INIT asynchronously. INIT lasts exactly 1 clk, then IDLE.
//  - INIT: sub_cmd all 00, load_en=0, cmd_ready=0, ld_ready=0, done=err=0. While rst high outputs match INIT,
//    so slices clear on every edge during reset and the first edge after it.
//  - IDLE: cmd_ready = !cfg_we. cfg_we in IDLE writes cfg at the edge (cfg takes priority over commands).
//    cfg_we in INIT/LOAD: ignored, err pulses next cycle.
//  - Default drive for every slice outside the active counter: sub_cmd=10, load_en=0.
//  - Accepted cmd, zero latency (outputs combinational from cmd_* and slice_data in the accept cycle; the slices
//    update at that same edge). cfg[cmd_base]==0 -> treated as nop, err pulses next cycle, stay IDLE.
//    reset: slices b..e get 00. nop: all 10. increment: slice b gets 01; slice j in (b,e] gets 01 iff slices
//    b..j-1 all equal {GRAN{1}}, else 10. All-ones counter wraps to zero; no carry crosses e.
//    load: latch b and e, beat counter k=0, go LOAD; accept-cycle outputs all idle.
//  - LOAD: cmd_ready=0, ld_ready=1. Beat accepted: load_en[b+k]=1, sub_cmd[b+k]=10, other slices 10; k++.
//    Beat for slice e: return to IDLE, done pulses next cycle. No ld_valid: all slices idle, wait indefinitely.
//  - load_en is only asserted in LOAD; never two load_en bits in one cycle.
//  - ld_valid outside LOAD: ignored (ld_ready=0). done/err registered, 1 cycle.
//  - rst mid-LOAD: aborts immediately; partial load discarded by INIT clear; cfg returns to all ones.
// TESTING
//  - Reset: rst 3 cycles, release -> sub_cmd all 00 through first post-reset edge, cmd_ready rises 1 cycle later.
//  - Carry: cfg=8'h11, counter base 0 = {0F,F,F}? set slices0..2=F,slice3=2; increment -> slices0..3 get 01 01 01 01;
//    slice4 gets 10; result 0x3000 in slices3..0.
//  - Wrap: cfg=8'hFF... use cfg=8'h81, slices0..6 all F, increment base 0 -> all 01 on 0..6, slice7 10, value 0.
//  - Load: cfg=8'h11, load base 4, beats A,B,C,D with a 2-cycle ld_valid gap after B -> load_en 0x10,0x20,0x40,0x80
//    in order, done pulse after D, cmd_ready only after done cycle begins.
//  - Errors: increment with cmd_base=3 under cfg=8'h11 -> all 10, err pulse; cfg_we during LOAD -> err, cfg unchanged.
//  - rst asserted after 2 of 4 load beats -> FSM INIT, ld_ready=0, slices cleared, cfg reads 8'hFF.

Source files
------------

// File: rtl/shared_counter_ctrl.sv
// Command front-end for a bank of subcounter slices partitioned into independent counters.
// Decodes per-counter commands into per-slice commands, ripples carries, and streams wide loads.
module shared_counter_ctrl #(
  parameter int  GRAN       = 4,
  parameter int  NUM_SLICES = 8,
  localparam int IDX_W      = $clog2(NUM_SLICES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [NUM_SLICES-1:0]        cfg_mask,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [IDX_W-1:0]             cmd_base,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [GRAN-1:0]              ld_data,
  input  logic [GRAN*NUM_SLICES-1:0]   slice_data,
  output logic [2*NUM_SLICES-1:0]      sub_cmd,
  output logic [NUM_SLICES-1:0]        load_en,
  output logic [GRAN*NUM_SLICES-1:0]   load_data,
  output logic                         done,
  output logic                         err
);

  typedef enum logic [1:0] {INIT, IDLE, LOAD} state_t;

  state_t                state, state_nxt;
  logic [NUM_SLICES-1:0] cfg, span, inc_go;
  logic [IDX_W-1:0]      span_end, ptr, last;
  logic                  in_cnt, carry;
  logic                  cfg_wr, ld_start, beat_fin, err_nxt;

  assign load_data = {NUM_SLICES{ld_data}};

  // Slices owned by the addressed counter, and which of them the +1 ripples into.
  always_comb begin
    span     = '0;
    inc_go   = '0;
    span_end = cmd_base;
    in_cnt   = 1'b0;
    carry    = 1'b1;
    for (int j = 0; j < NUM_SLICES; j++) begin
      if (IDX_W'(j) == cmd_base) in_cnt = 1'b1;
      else if (cfg[j])           in_cnt = 1'b0;
      span[j] = in_cnt;
      if (in_cnt) begin
        span_end  = IDX_W'(j);
        inc_go[j] = carry;
        carry     = carry & (&slice_data[j*GRAN +: GRAN]);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    sub_cmd   = {NUM_SLICES{2'b10}};
    load_en   = '0;
    cmd_ready = 1'b0;
    ld_ready  = 1'b0;
    cfg_wr    = 1'b0;
    ld_start  = 1'b0;
    beat_fin  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      INIT: begin
        sub_cmd   = '0;
        err_nxt   = cfg_we;
        state_nxt = IDLE;
      end
      IDLE: begin
        cmd_ready = !cfg_we;
        cfg_wr    = cfg_we;
        if (cmd_valid && !cfg_we) begin
          if (!cfg[cmd_base]) err_nxt = 1'b1;
          else begin
            case (cmd_op)
              2'b00: for (int j = 0; j < NUM_SLICES; j++)
                       if (span[j]) sub_cmd[2*j +: 2] = 2'b00;
              2'b01: for (int j = 0; j < NUM_SLICES; j++)
                       if (inc_go[j]) sub_cmd[2*j +: 2] = 2'b01;
              2'b11: begin
                ld_start  = 1'b1;
                state_nxt = LOAD;
              end
              default: ;
            endcase
          end
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        err_nxt  = cfg_we;
        if (ld_valid) begin
          load_en[ptr] = 1'b1;
          if (ptr == last) begin
            beat_fin  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cfg   <= '1;
      ptr   <= '0;
      last  <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= beat_fin;
      err   <= err_nxt;
      // Slice 0 is always the base of some counter.
      if (cfg_wr) cfg <= cfg_mask | NUM_SLICES'(1);
      if (ld_start) begin
        ptr  <= cmd_base;
        last <= span_end;
      end else if (ld_ready && ld_valid) begin
        ptr  <= ptr + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_shared_counter_ctrl.sv
// Bench for shared_counter_ctrl: behavioural slice bank and command model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_shared_counter_ctrl;
  localparam int GRAN = 4;
  localparam int NS   = 8;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cfg_we = 1'b0, cmd_valid = 1'b0, ld_valid = 1'b0;
  logic [7:0]  cfg_mask = '0;
  logic [1:0]  cmd_op = '0;
  logic [2:0]  cmd_base = '0;
  logic [3:0]  ld_data = '0;
  logic [31:0] bank = '0, bank_nxt;
  logic        cmd_ready, ld_ready, done, err;
  logic [15:0] sub_cmd;
  logic [7:0]  load_en;
  logic [31:0] load_data;

  shared_counter_ctrl #(.GRAN(GRAN), .NUM_SLICES(NS)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_mask(cfg_mask),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_base(cmd_base),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .slice_data(bank),
    .sub_cmd(sub_cmd), .load_en(load_en), .load_data(load_data), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Slice bank: behaves like the real subcounters driven by the DUT.
  always_comb begin
    bank_nxt = bank;
    for (int j = 0; j < NS; j++) begin
      if (load_en[j])                bank_nxt[4*j +: 4] = load_data[4*j +: 4];
      else if (sub_cmd[2*j +: 2] == 2'b00) bank_nxt[4*j +: 4] = 4'h0;
      else if (sub_cmd[2*j +: 2] == 2'b01) bank_nxt[4*j +: 4] = bank[4*j +: 4] + 4'h1;
    end
  end
  always @(posedge clk) bank <= bank_nxt;

  int n_cmp = 0, n_fail = 0;

  // Literal expectations queued by the stimulus, checked by the compare process.
  int          lit_k[8];
  logic [63:0] lit_e[8];
  string       lit_n[8];
  int          lit_cnt = 0;

  typedef enum {P_INIT, P_IDLE, P_LOAD} ph_t;
  ph_t        m_ph = P_INIT;
  logic [7:0] m_cfg = 8'hFF;
  int         q[$];
  logic       m_done = 1'b0, m_err = 1'b0;

  function automatic void check(string n, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endfunction

  function automatic logic [63:0] pick(int k);
    case (k)
      0: return 64'(bank);
      1: return 64'(load_en);
      2: return 64'(sub_cmd);
      3: return 64'(err);
      4: return 64'(done);
      5: return 64'(cmd_ready);
      default: return 64'(ld_ready);
    endcase
  endfunction

  function automatic void model_cycle();
    logic [15:0] es  = 16'hAAAA;
    logic [7:0]  el  = '0;
    logic        ecr = 1'b0, elr = 1'b0, edn = m_done, eer = m_err, nd = 1'b0, ne = 1'b0;
    logic [63:0] v, nv;
    int b, e;
    if (rst) begin
      es = '0; edn = 1'b0; eer = 1'b0;
      m_ph = P_INIT; m_cfg = 8'hFF; q.delete();
    end else begin
      case (m_ph)
        P_INIT: begin es = '0; ne = cfg_we; m_ph = P_IDLE; end
        P_IDLE: begin
          ecr = !cfg_we;
          if (cfg_we) m_cfg = cfg_mask | 8'h01;
          else if (cmd_valid) begin
            b = int'(cmd_base);
            if (!m_cfg[b]) ne = 1'b1;
            else begin
              e = b;
              while (e < NS-1 && !m_cfg[e+1]) e++;
              case (cmd_op)
                2'b00: for (int j = b; j <= e; j++) es[2*j +: 2] = 2'b00;
                2'b01: begin
                  v = '0;
                  for (int j = e; j >= b; j--) v = (v << 4) | 64'(bank[4*j +: 4]);
                  nv = (v + 64'd1) & ((64'd1 << (4*(e-b+1))) - 64'd1);
                  for (int j = b; j <= e; j++)
                    if (nv[4*(j-b) +: 4] != v[4*(j-b) +: 4]) es[2*j +: 2] = 2'b01;
                end
                2'b11: begin
                  for (int j = b; j <= e; j++) q.push_back(j);
                  m_ph = P_LOAD;
                end
                default: ;
              endcase
            end
          end
        end
        default: begin
          elr = 1'b1;
          ne  = cfg_we;
          if (ld_valid && q.size() > 0) begin
            el[q.pop_front()] = 1'b1;
            if (q.size() == 0) begin nd = 1'b1; m_ph = P_IDLE; end
          end
        end
      endcase
    end
    m_done = nd;
    m_err  = ne;
    check("sub_cmd",   64'(sub_cmd),   64'(es));
    check("load_en",   64'(load_en),   64'(el));
    check("load_data", 64'(load_data), 64'({NS{ld_data}}));
    check("cmd_ready", 64'(cmd_ready), 64'(ecr));
    check("ld_ready",  64'(ld_ready),  64'(elr));
    check("done",      64'(done),      64'(edn));
    check("err",       64'(err),       64'(eer));
  endfunction

  always @(negedge clk) begin
    model_cycle();
    for (int i = 0; i < lit_cnt; i++) check(lit_n[i], pick(lit_k[i]), lit_e[i]);
  end

  task automatic lit(input int k, input logic [63:0] e, input string n);
    lit_k[lit_cnt] = k; lit_e[lit_cnt] = e; lit_n[lit_cnt] = n;
    lit_cnt++;
  endtask

  task automatic step();
    @(posedge clk); #1;
    lit_cnt = 0;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [2:0] b);
    int n = 0;
    cmd_op = op; cmd_base = b; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready) begin
      n++;
      if (n > 50) begin
        $display("FAIL cmd_timeout: cmd_ready=%0b expected 1", cmd_ready);
        $fatal(1);
      end
      @(negedge clk);
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic beat(input logic [3:0] d);
    int n = 0;
    ld_data = d; ld_valid = 1'b1;
    @(negedge clk);
    while (!ld_ready) begin
      n++;
      if (n > 50) begin
        $display("FAIL beat_timeout: ld_ready=%0b expected 1", ld_ready);
        $fatal(1);
      end
      @(negedge clk);
    end
    step();
    ld_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic [7:0] m);
    cfg_we = 1'b1; cfg_mask = m;
    lit(5, 64'h0, "cfg_cmd_ready");
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    repeat (3) begin
      lit(2, 64'h0, "rst_sub"); lit(5, 64'h0, "rst_cmd_ready");
      step();
    end
    rst = 1'b0;
    lit(2, 64'h0, "init_sub"); lit(5, 64'h0, "init_cmd_ready");
    step();
    lit(5, 64'h1, "idle_cmd_ready");
    ld_valid = 1'b1;
    lit(6, 64'h0, "idle_ld_ready"); lit(1, 64'h0, "idle_load_en");
    step();
    ld_valid = 1'b0;

    // cfg all ones: every slice is its own counter
    lit(2, 64'hAA6A, "inc_b3_sub"); cmd(2'b01, 3'd3);
    lit(0, 64'h1000, "inc_b3_bank"); step();
    lit(2, 64'hAAAA, "nop_sub"); cmd(2'b10, 3'd0);
    lit(2, 64'hAA2A, "reset_b3_sub"); cmd(2'b00, 3'd3);
    lit(0, 64'h0, "reset_b3_bank"); step();

    // carry across slices 0..3
    set_cfg(8'h11);
    lit(2, 64'hAAAA, "ld_accept_sub"); cmd(2'b11, 3'd0);
    beat(4'hF); beat(4'hF); beat(4'hF); beat(4'h2);
    lit(4, 64'h1, "done_b0"); lit(0, 64'h2FFF, "ld_b0_bank"); step();
    lit(2, 64'hAA55, "carry_sub"); cmd(2'b01, 3'd0);
    lit(0, 64'h3000, "carry_bank"); step();

    // load base 4 with a gap after the second beat
    cmd(2'b11, 3'd4);
    lit(1, 64'h10, "load_en_A"); beat(4'hA);
    lit(1, 64'h20, "load_en_B"); beat(4'hB);
    repeat (2) begin
      lit(1, 64'h0, "gap_load_en"); lit(6, 64'h1, "gap_ld_ready"); lit(5, 64'h0, "gap_cmd_ready");
      step();
    end
    lit(1, 64'h40, "load_en_C"); beat(4'hC);
    lit(1, 64'h80, "load_en_D"); lit(5, 64'h0, "last_beat_cmd_ready"); lit(4, 64'h0, "done_early");
    beat(4'hD);
    lit(4, 64'h1, "done_D"); lit(5, 64'h1, "done_cmd_ready"); lit(0, 64'hDCBA3000, "ld_b4_bank");
    step();

    // bad base, then cfg_we during LOAD
    lit(2, 64'hAAAA, "bad_base_sub"); cmd(2'b01, 3'd3);
    lit(3, 64'h1, "bad_base_err"); lit(0, 64'hDCBA3000, "bad_base_bank"); step();
    cmd(2'b11, 3'd0);
    cfg_we = 1'b1; cfg_mask = 8'hFF;
    lit(6, 64'h1, "load_cfgwe_ld_ready"); step();
    cfg_we = 1'b0;
    lit(3, 64'h1, "load_cfgwe_err");
    beat(4'h4); beat(4'h3); beat(4'h2); beat(4'h1);
    lit(0, 64'hDCBA1234, "ld_b0_bank2"); step();
    lit(2, 64'hAAAA, "cfg_kept_sub"); cmd(2'b01, 3'd1);
    lit(3, 64'h1, "cfg_kept_err"); step();

    // wrap over slices 0..6
    set_cfg(8'h81);
    cmd(2'b11, 3'd0);
    repeat (7) beat(4'hF);
    lit(0, 64'hDFFFFFFF, "wrap_pre_bank"); step();
    lit(2, 64'h9555, "wrap_sub"); cmd(2'b01, 3'd0);
    lit(0, 64'hD0000000, "wrap_bank"); step();

    // reset in the middle of a load
    set_cfg(8'h11);
    cmd(2'b11, 3'd4);
    beat(4'h1); beat(4'h2);
    rst = 1'b1;
    lit(6, 64'h0, "mid_rst_ld_ready"); lit(2, 64'h0, "mid_rst_sub"); lit(1, 64'h0, "mid_rst_load_en");
    step();
    lit(0, 64'h0, "mid_rst_bank"); step();
    rst = 1'b0;
    step();
    lit(2, 64'hA6AA, "cfg_ff_sub"); cmd(2'b01, 3'd5);
    lit(3, 64'h0, "cfg_ff_err"); lit(0, 64'h00100000, "cfg_ff_bank"); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
